decode_stage_param: RTL and testbench
=====================================

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width for PC, register data and immediates; legal values are 32 and above.
REQ-002 The block SHALL have parameter BNE_EN, default 1, which enables not-equal branch evaluation; when 0, BranchNeD is ignored.
REQ-003 The block SHALL have parameter RF_ZERO_RST, default 1, which clears all registers on reset; when 0, only the pipeline register is reset.
REQ-004 CLk  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 StallD  in  1  hold the IF/ID pipeline register.
REQ-007 FlushD  in  1  bubble the IF/ID pipeline register.
REQ-008 InstrF  in  32  fetched instruction.
REQ-009 PcPlus4F  in  DATA_W  fetch PC+4.
REQ-010 RegWriteW, WriteRegW, ResultW  in  1/5/DATA_W  writeback port.
REQ-011 ALUoutM  in  DATA_W  memory-stage ALU result.
REQ-012 ForwardAD, ForwardBD  in  2/2  compare-operand select: 00 = register file, 01 = ALUoutM, 10 = ResultW, 11 = register file.
REQ-013 JumpD, BranchD, BranchNeD  in  1/1/1  control-unit decode.
REQ-014 InstrD  out  32  registered instruction; PcPlus4D  out  DATA_W  registered PC+4; ValidD  out  1  slot holds a real instruction.
REQ-015 RD1D, RD2D  out  DATA_W  register-file read data, including write bypass.
REQ-016 RsD, RtD, RdE_D  out  5/5/5  InstrD[25:21], [20:16], [15:11].
REQ-017 signImmD  out  DATA_W  InstrD[15:0] sign-extended.
REQ-018 PcBranchD, PcJumpD  out  DATA_W/DATA_W  branch target and jump target.
REQ-019 PcScrD  out  2  next-PC select: 00 = sequential, 01 = branch, 10 = jump.

Function
REQ-020 The IF/ID register SHALL load InstrF and PcPlus4F and set ValidD=1 on each clock edge when StallD=0 and FlushD=0.
REQ-021 When StallD=1 and FlushD=0, the IF/ID register SHALL hold InstrD, PcPlus4D and ValidD unchanged.
REQ-022 When FlushD=1, the block SHALL clear InstrD to 0 and ValidD to 0 and SHALL hold PcPlus4D, whatever the value of StallD (flush wins).
REQ-023 The register file SHALL hold 32 entries of DATA_W bits; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-024 The register file SHALL write ResultW into WriteRegW on the clock edge when RegWriteW=1 and WriteRegW!=0.
REQ-025 Reads SHALL be combinational on RsD/RtD.
REQ-026 When RegWriteW=1, WriteRegW equals the read address and the read address is not 0, the read SHALL return ResultW in the same cycle (write-first bypass).
REQ-027 Compare operand A SHALL be selected from RD1D, ALUoutM or ResultW by ForwardAD; operand B SHALL be selected likewise by ForwardBD.
REQ-028 EqualD SHALL be 1 when A equals B over the full DATA_W bits.
REQ-029 takenD SHALL equal BranchD & ValidD & (BNE_EN & BranchNeD ? ~EqualD : EqualD).
REQ-030 PcScrD[1] SHALL equal JumpD & ValidD.
REQ-031 PcScrD[0] SHALL equal takenD & ~PcScrD[1], so jump has priority and PcScrD never equals 11.
REQ-032 PcBranchD SHALL equal PcPlus4D + (signImmD << 2), truncated to DATA_W bits (wrap-around, no carry out).
REQ-033 PcJumpD SHALL equal {PcPlus4D[DATA_W-1:28], InstrD[25:0], 2'b00}.
REQ-034 A bubble (ValidD=0) SHALL drive PcScrD=00 regardless of JumpD and BranchD.

Reset
REQ-035 Reset=0 SHALL immediately, without a clock edge, set InstrD=0, PcPlus4D=0 and ValidD=0; when RF_ZERO_RST=1 it SHALL also clear all registers to 0.
REQ-036 During and after reset, all derived outputs SHALL follow from the cleared state: PcScrD=00, signImmD=0, RsD/RtD/RdE_D=0.
REQ-037 Reset asserted mid-stall or mid-writeback SHALL override StallD, FlushD and RegWriteW.
REQ-038 The first rising edge with Reset=1 SHALL perform normal loading.

Verification
REQ-039 Reset scenario: assert Reset=0 between clock edges with InstrD nonzero -> InstrD, ValidD and PcScrD read 0 before the next edge, and every register reads 0.
REQ-040 Write bypass scenario: write R5=0x1234 with Rs=5 in the same cycle -> RD1D=0x1234 in that cycle; a write to R0 of 0xFFFF -> R0 still reads 0.
REQ-041 Forwarding scenario: with BEQ, RD1D=1, ALUoutM=7, ResultW=7, ForwardAD=01, ForwardBD=10 -> PcScrD=01; set ForwardBD=00 with RD2D=3 -> PcScrD=00; with BNE -> PcScrD=01.
REQ-042 Branch target wrap scenario: PcPlus4D=0xFFFFFFFC and imm=0x0002 -> PcBranchD=0x00000004; imm=0x8000 with PcPlus4D=0x00020000 -> PcBranchD=0x00000000.
REQ-043 Stall/flush scenario: StallD=1 holds InstrD for 3 edges; StallD=1 with FlushD=1 -> InstrD=0 and ValidD=0.
REQ-044 Jump priority scenario: JumpD=1 with BranchD=1 and equal operands -> PcScrD=10 and PcJumpD={PC[31:28], target, 00}; the same inputs with ValidD=0 -> PcScrD=00.

Source files
------------

// File: rtl/decode_stage_param.sv
// Decode stage of a 5-stage MIPS-style pipeline.
// Holds the IF/ID pipeline register, a 32-entry register file with write-first
// bypass, the early branch comparator with forwarding muxes, and next-PC selection.
//
// Ports:
//   CLk, Reset                  clock, asynchronous active-low reset
//   StallD, FlushD              hold / bubble the IF/ID register (flush wins)
//   InstrF, PcPlus4F            fetched instruction and PC+4
//   RegWriteW, WriteRegW,
//   ResultW                     writeback port into the register file
//   ALUoutM                     memory-stage ALU result (forwarding source)
//   ForwardAD, ForwardBD        compare operand select (01 ALUoutM, 10 ResultW, else RF)
//   JumpD, BranchD, BranchNeD   control-unit decode
//   InstrD, PcPlus4D, ValidD    IF/ID register contents
//   RD1D, RD2D                  register read data (with bypass)
//   RsD, RtD, RdE_D             register fields of InstrD
//   signImmD                    sign-extended immediate
//   PcBranchD, PcJumpD          branch and jump targets
//   PcScrD                      next-PC select (00 seq, 01 branch, 10 jump)
module decode_stage_param #(
    parameter int unsigned DATA_W      = 32,
    parameter bit          BNE_EN      = 1'b1,
    parameter bit          RF_ZERO_RST = 1'b1
) (
    input  logic              CLk,
    input  logic              Reset,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic [31:0]       InstrF,
    input  logic [DATA_W-1:0] PcPlus4F,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [DATA_W-1:0] ALUoutM,
    input  logic [1:0]        ForwardAD,
    input  logic [1:0]        ForwardBD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              BranchNeD,
    output logic [31:0]       InstrD,
    output logic [DATA_W-1:0] PcPlus4D,
    output logic              ValidD,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [4:0]        RsD,
    output logic [4:0]        RtD,
    output logic [4:0]        RdE_D,
    output logic [DATA_W-1:0] signImmD,
    output logic [DATA_W-1:0] PcBranchD,
    output logic [DATA_W-1:0] PcJumpD,
    output logic [1:0]        PcScrD
);

    logic [31:0]       instr_q;
    logic [DATA_W-1:0] pc_plus4_q;
    logic              valid_q;
    logic [DATA_W-1:0] rf_q [32];
    logic              rf_we;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              equal_d;
    logic              taken_d;
    logic              jump_sel;

    // IF/ID pipeline register; a flush bubbles the slot but keeps the PC.
    always_ff @(posedge CLk or negedge Reset) begin
        if (!Reset) begin
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (FlushD) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!StallD) begin
            instr_q    <= InstrF;
            pc_plus4_q <= PcPlus4F;
            valid_q    <= 1'b1;
        end
    end

    // Gating with Reset keeps the non-reset variant from writing while reset is held.
    assign rf_we = RegWriteW && (WriteRegW != 5'd0) && Reset;

    generate
        if (RF_ZERO_RST) begin : g_rf_rst
            always_ff @(posedge CLk or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < 32; i++) begin
                        rf_q[i] <= '0;
                    end
                end else if (rf_we) begin
                    rf_q[WriteRegW] <= ResultW;
                end
            end
        end else begin : g_rf_norst
            always_ff @(posedge CLk) begin
                if (rf_we) begin
                    rf_q[WriteRegW] <= ResultW;
                end
            end
        end
    endgenerate

    assign InstrD   = instr_q;
    assign PcPlus4D = pc_plus4_q;
    assign ValidD   = valid_q;
    assign RsD      = instr_q[25:21];
    assign RtD      = instr_q[20:16];
    assign RdE_D    = instr_q[15:11];
    assign signImmD = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};

    // Register 0 is hard-wired; a same-cycle write to the read address is bypassed.
    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (RsD != 5'd0) begin
            RD1D = (RegWriteW && (WriteRegW == RsD)) ? ResultW : rf_q[RsD];
        end
        if (RtD != 5'd0) begin
            RD2D = (RegWriteW && (WriteRegW == RtD)) ? ResultW : rf_q[RtD];
        end
    end

    always_comb begin
        cmp_a = RD1D;
        cmp_b = RD2D;
        case (ForwardAD)
            2'b01:   cmp_a = ALUoutM;
            2'b10:   cmp_a = ResultW;
            default: cmp_a = RD1D;
        endcase
        case (ForwardBD)
            2'b01:   cmp_b = ALUoutM;
            2'b10:   cmp_b = ResultW;
            default: cmp_b = RD2D;
        endcase
    end

    assign equal_d  = (cmp_a == cmp_b);
    assign taken_d  = BranchD & valid_q & ((BNE_EN && BranchNeD) ? ~equal_d : equal_d);
    assign jump_sel = JumpD & valid_q;
    assign PcScrD   = {jump_sel, taken_d & ~jump_sel};

    // Shift truncates to DATA_W, so the add wraps with no carry out.
    assign PcBranchD = pc_plus4_q + (signImmD << 2);
    assign PcJumpD   = {pc_plus4_q[DATA_W-1:28], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage_param.sv
module tb_decode_stage_param;

    logic        CLk;
    logic        Reset;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PcPlus4F;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [31:0] ALUoutM;
    logic [1:0]  ForwardAD;
    logic [1:0]  ForwardBD;
    logic        JumpD;
    logic        BranchD;
    logic        BranchNeD;
    logic [31:0] InstrD;
    logic [31:0] PcPlus4D;
    logic        ValidD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdE_D;
    logic [31:0] signImmD;
    logic [31:0] PcBranchD;
    logic [31:0] PcJumpD;
    logic [1:0]  PcScrD;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage_param #(
        .DATA_W      (32),
        .BNE_EN      (1'b1),
        .RF_ZERO_RST (1'b1)
    ) dut (
        .CLk       (CLk),
        .Reset     (Reset),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstrF    (InstrF),
        .PcPlus4F  (PcPlus4F),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .ALUoutM   (ALUoutM),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .JumpD     (JumpD),
        .BranchD   (BranchD),
        .BranchNeD (BranchNeD),
        .InstrD    (InstrD),
        .PcPlus4D  (PcPlus4D),
        .ValidD    (ValidD),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .RsD       (RsD),
        .RtD       (RtD),
        .RdE_D     (RdE_D),
        .signImmD  (signImmD),
        .PcBranchD (PcBranchD),
        .PcJumpD   (PcJumpD),
        .PcScrD    (PcScrD)
    );

    initial CLk = 1'b0;
    always #5 CLk = ~CLk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic tick();
        @(posedge CLk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        InstrF   = instr;
        PcPlus4F = pc;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        RegWriteW = 1'b1;
        WriteRegW = addr;
        ResultW   = data;
        tick();
        RegWriteW = 1'b0;
    endtask

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        Reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; InstrF = '0; PcPlus4F = '0;
        RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0; ALUoutM = '0;
        ForwardAD = 2'b00; ForwardBD = 2'b00; JumpD = 1'b0; BranchD = 1'b0; BranchNeD = 1'b0;

        // Reset state
        #2;
        check("rst_instr", InstrD, 32'h0);
        check("rst_valid", {31'h0, ValidD}, 32'h0);
        check("rst_pc", PcPlus4D, 32'h0);
        check("rst_pcscr", {30'h0, PcScrD}, 32'h0);
        check("rst_imm", signImmD, 32'h0);
        check("rst_rs", {27'h0, RsD}, 32'h0);
        #1 Reset = 1'b1;

        // First edge after reset loads normally
        load(mk_i(6'h04, 5'd5, 5'd6, 16'h0000), 32'h0000_0100);
        check("load_valid", {31'h0, ValidD}, 32'h1);
        check("load_instr", InstrD, 32'h10A6_0000);
        check("load_pc", PcPlus4D, 32'h0000_0100);

        // Write-first bypass on R5
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h1234;
        #1 check("bypass_rd1", RD1D, 32'h1234);
        tick();
        RegWriteW = 1'b0;
        #1 check("r5_stored", RD1D, 32'h1234);

        // R0 ignores writes
        load(mk_i(6'h00, 5'd0, 5'd0, 16'h0), 32'h0);
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFF;
        #1 check("r0_bypass", RD1D, 32'h0);
        tick();
        RegWriteW = 1'b0;
        #1 check("r0_after", RD1D, 32'h0);

        // Forwarding into the branch comparator
        wr(5'd1, 32'd1);
        wr(5'd2, 32'd3);
        BranchD = 1'b1;
        load(mk_i(6'h04, 5'd1, 5'd2, 16'h0), 32'h200);
        check("fwd_rd1", RD1D, 32'd1);
        check("fwd_rd2", RD2D, 32'd3);
        ALUoutM = 32'd7; ResultW = 32'd7; ForwardAD = 2'b01; ForwardBD = 2'b10;
        #1 check("beq_fwd_eq", {30'h0, PcScrD}, 32'h1);
        ForwardBD = 2'b00;
        #1 check("beq_fwd_ne", {30'h0, PcScrD}, 32'h0);
        BranchNeD = 1'b1;
        #1 check("bne_fwd_ne", {30'h0, PcScrD}, 32'h1);
        ForwardAD = 2'b11; ForwardBD = 2'b11; BranchNeD = 1'b0;
        #1 check("beq_rf_11", {30'h0, PcScrD}, 32'h0);
        BranchNeD = 1'b1;
        #1 check("bne_rf_11", {30'h0, PcScrD}, 32'h1);
        BranchD = 1'b0; BranchNeD = 1'b0; ForwardAD = 2'b00; ForwardBD = 2'b00;

        // Branch target wrap-around
        load(mk_i(6'h04, 5'd0, 5'd0, 16'h0002), 32'hFFFF_FFFC);
        check("br_wrap_pos", PcBranchD, 32'h0000_0004);
        load(mk_i(6'h04, 5'd0, 5'd0, 16'h8000), 32'h0002_0000);
        check("imm_neg", signImmD, 32'hFFFF_8000);
        check("br_wrap_neg", PcBranchD, 32'h0000_0000);

        // Field decode, then stall for three edges, then stall+flush
        load(32'h1234_5678, 32'h400);
        check("rs_field", {27'h0, RsD}, 32'd17);
        check("rt_field", {27'h0, RtD}, 32'd20);
        check("rd_field", {27'h0, RdE_D}, 32'd10);
        check("imm_pos", signImmD, 32'h0000_5678);
        StallD = 1'b1; InstrF = 32'hCAFE_F00D; PcPlus4F = 32'h999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_instr%0d", i), InstrD, 32'h1234_5678);
            check($sformatf("stall_pc%0d", i), PcPlus4D, 32'h400);
            check($sformatf("stall_valid%0d", i), {31'h0, ValidD}, 32'h1);
        end
        FlushD = 1'b1;
        tick();
        check("flush_instr", InstrD, 32'h0);
        check("flush_valid", {31'h0, ValidD}, 32'h0);
        check("flush_pc", PcPlus4D, 32'h400);
        StallD = 1'b0; FlushD = 1'b0;

        // Jump wins over a taken branch; a bubble selects sequential
        JumpD = 1'b1; BranchD = 1'b1; ALUoutM = 32'd7; ForwardAD = 2'b01; ForwardBD = 2'b01;
        load({6'h02, 26'h0AB_CDEF}, 32'hA000_0010);
        check("jump_pcscr", {30'h0, PcScrD}, 32'h2);
        check("jump_target", PcJumpD, 32'hA2AF_37BC);
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        check("bubble_valid", {31'h0, ValidD}, 32'h0);
        check("bubble_pcscr", {30'h0, PcScrD}, 32'h0);
        JumpD = 1'b0;
        #1 check("bubble_branch", {30'h0, PcScrD}, 32'h0);
        BranchD = 1'b0; ForwardAD = 2'b00; ForwardBD = 2'b00;

        // Reset asserted mid-stall and mid-writeback
        load(32'h1234_5678, 32'h400);
        StallD = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'hDEAD;
        #2 Reset = 1'b0;
        #1;
        check("midrst_instr", InstrD, 32'h0);
        check("midrst_valid", {31'h0, ValidD}, 32'h0);
        check("midrst_pc", PcPlus4D, 32'h0);
        check("midrst_pcscr", {30'h0, PcScrD}, 32'h0);
        tick();
        RegWriteW = 1'b0; StallD = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load(mk_i(6'h00, 5'(2 * i), 5'(2 * i + 1), 16'h0), 32'h0);
            check($sformatf("rf_clr%0d", 2 * i), RD1D, 32'h0);
            check($sformatf("rf_clr%0d", 2 * i + 1), RD2D, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
